// File: rtl/seg_pkg.sv
// Shared types and the active-low 7-segment lookup table for the display scanner.
package seg_pkg;

  // Segment pattern {a,b,c,d,e,f,g}, bit 6 = a.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Active-low decode for BCD 0..9; codes 10..15 leave every segment dark.
  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low segment pattern decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed multi-digit 7-segment driver: prescaled digit scan, tear-free
// frame capture, leading-zero blanking, per-digit blink and registered pin outputs.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  output logic [6:0]            display,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  localparam seg_t              DISP_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [FC_W-1:0]     fc;
  logic                phase;
  logic [4*DIGITS-1:0] frame_bcd;
  logic [DIGITS-1:0]   frame_dp;

  logic                tick;
  logic [4*DIGITS-1:0] eff_bcd;
  logic [DIGITS-1:0]   eff_dp;
  logic [3:0]          digit;
  logic                digit_dp;
  logic                digit_blink;
  logic                lz_blank;
  logic                blank;
  logic [DIGITS-1:0]   sel;
  seg_t                dec_seg;
  seg_t                seg_lo;
  logic [DIGITS-1:0]   an_on;

  assign tick = (cnt == CNT_LAST);

  // Slot 0 decodes the live inputs so the captured frame and its first digit agree.
  assign eff_bcd = (idx == '0) ? bcd   : frame_bcd;
  assign eff_dp  = (idx == '0) ? dp_in : frame_dp;

  // Select the current digit and decide leading-zero blanking from the frame contents.
  always_comb begin
    logic all_zero;
    digit       = eff_bcd[3:0];
    digit_dp    = eff_dp[0];
    digit_blink = blink_mask[0];
    sel         = '0;
    lz_blank    = 1'b0;
    all_zero    = 1'b1;
    sel[0]      = (idx == '0);
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (eff_bcd[4*i +: 4] != 4'd0) all_zero = 1'b0;
      sel[i] = (idx == IDX_W'(i));
      if (sel[i]) begin
        digit       = eff_bcd[4*i +: 4];
        digit_dp    = eff_dp[i];
        digit_blink = blink_mask[i];
        lz_blank    = blank_lz & all_zero;
      end
    end
  end

  seg_decode u_decode (
    .bcd (digit),
    .seg (dec_seg)
  );

  assign blank  = lz_blank | (phase & digit_blink);
  assign seg_lo = blank ? SEG_OFF : dec_seg;
  assign an_on  = blank ? '0 : sel;

  // Prescaler, digit index, frame capture and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      fc        <= '0;
      phase     <= 1'b0;
      frame_bcd <= '0;
      frame_dp  <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (idx == '0) begin
        frame_bcd <= bcd;
        frame_dp  <= dp_in;
      end
      if (idx == IDX_LAST) begin
        if (fc == FC_LAST) begin
          fc    <= '0;
          phase <= ~phase;
        end else begin
          fc <= fc + FC_W'(1);
        end
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pin registers: load the current slot's pattern on each tick, in pin polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      display <= DISP_OFF;
      dp      <= DP_OFF;
      anode   <= AN_OFF;
    end else if (tick) begin
      display <= (SEG_ACTIVE_LOW != 0) ? seg_lo : ~seg_lo;
      dp      <= (SEG_ACTIVE_LOW != 0) ? ~(digit_dp & ~blank) : (digit_dp & ~blank);
      anode   <= (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
    end
  end

endmodule
